// File: rtl/rvi_decode_stage.sv
// RV32I/RV64I decode stage: classifies a raw instruction, extracts fields and the
// immediate, and presents the result through a two-entry (output + skid) buffer.
module rvi_decode_stage #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [6:0]           out_opcode,
  output logic [9:0]           out_funct,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [XLEN-1:0]      out_imm,
  output logic [2:0]           out_fmt,
  output logic                 out_is_word,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("rvi_decode_stage: XLEN must be 32 or 64");
  end

  localparam bit IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Encoding doubles as the per-entry valid bits: [0] output reg, [1] skid reg.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [9:0]      funct;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            is_word;
    logic            illegal;
  } dec_t;

  state_e                state_r, state_n;
  dec_t                  dec_s, out_r, skid_r;
  logic [31:0]           imm32_s;
  logic [ILL_CNT_W-1:0]  ill_cnt_r;
  logic [6:0]            opc_s, f7_s;
  logic [2:0]            f3_s;
  logic                  shift_s, take_s, accept_s;

  assign opc_s    = in_inst[6:0];
  assign f3_s     = in_inst[14:12];
  assign f7_s     = in_inst[31:25];
  assign shift_s  = (f3_s == 3'b001) || (f3_s == 3'b101);
  assign take_s   = out_valid & out_ready;
  assign accept_s = in_valid & in_ready;

  // Instruction decode: format, normalised funct, legality, fields and immediate.
  always_comb begin
    dec_s         = {$bits(dec_t){1'b0}};
    imm32_s       = 32'h0000_0000;
    dec_s.pc      = in_pc;
    dec_s.opcode  = opc_s;
    dec_s.funct   = {7'b0000000, f3_s};
    dec_s.fmt     = FMT_I;
    case (opc_s)
      OPC_LOAD:     dec_s.illegal = (f3_s == 3'b111) ||
                                    (!IS64 && ((f3_s == 3'b011) || (f3_s == 3'b110)));
      OPC_MISC_MEM: dec_s.fmt = FMT_I;
      OPC_SYSTEM:   dec_s.fmt = FMT_I;
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        if (shift_s) begin
          dec_s.funct = IS64 ? {in_inst[31:26], 1'b0, f3_s} : {f7_s, f3_s};
        end else begin
          dec_s.funct = {7'b0000000, f3_s};
        end
        if (opc_s == OPC_OP_IMM_32) begin
          dec_s.is_word = IS64;
          dec_s.illegal = !IS64;
        end else begin
          dec_s.illegal = !IS64 && shift_s && in_inst[25];
        end
      end
      OPC_JALR:     dec_s.illegal = (f3_s != 3'b000);
      OPC_STORE: begin
        dec_s.fmt     = FMT_S;
        dec_s.illegal = IS64 ? (f3_s >= 3'b100) : (f3_s >= 3'b011);
      end
      OPC_BRANCH: begin
        dec_s.fmt     = FMT_B;
        dec_s.illegal = (f3_s == 3'b010) || (f3_s == 3'b011);
      end
      OPC_LUI, OPC_AUIPC: dec_s.fmt = FMT_U;
      OPC_JAL:      dec_s.fmt = FMT_J;
      OPC_OP: begin
        dec_s.fmt     = FMT_R;
        dec_s.funct   = {f7_s, f3_s};
        dec_s.illegal = ((f7_s != 7'b0000000) && (f7_s != 7'b0100000)) ||
                        ((f7_s == 7'b0100000) && (f3_s != 3'b000) && (f3_s != 3'b101));
      end
      OPC_OP_32: begin
        dec_s.fmt     = FMT_R;
        dec_s.funct   = {f7_s, f3_s};
        dec_s.is_word = IS64;
        dec_s.illegal = !IS64;
      end
      default: begin
        dec_s.fmt     = FMT_R;
        dec_s.illegal = 1'b1;
      end
    endcase
    dec_s.illegal = dec_s.illegal | (in_inst[1:0] != 2'b11);

    case (dec_s.fmt)
      FMT_R: begin
        dec_s.rd  = in_inst[11:7];
        dec_s.rs1 = in_inst[19:15];
        dec_s.rs2 = in_inst[24:20];
      end
      FMT_I: begin
        dec_s.rd  = in_inst[11:7];
        dec_s.rs1 = in_inst[19:15];
        imm32_s   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      FMT_S: begin
        dec_s.rs1 = in_inst[19:15];
        dec_s.rs2 = in_inst[24:20];
        imm32_s   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      FMT_B: begin
        dec_s.rs1 = in_inst[19:15];
        dec_s.rs2 = in_inst[24:20];
        imm32_s   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
      end
      FMT_U: begin
        dec_s.rd  = in_inst[11:7];
        imm32_s   = {in_inst[31:12], 12'h000};
      end
      FMT_J: begin
        dec_s.rd  = in_inst[11:7];
        imm32_s   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
      end
      default: imm32_s = 32'h0000_0000;
    endcase
    dec_s.imm = XLEN'($signed(imm32_s));
  end

  // Buffer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_n;
    end
  end

  // Buffer next-state; flush wins over any accept.
  always_comb begin
    state_n = state_r;
    if (flush) begin
      state_n = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_n = accept_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (accept_s && !take_s) begin
            state_n = ST_FULL;
          end else if (take_s && !accept_s) begin
            state_n = ST_EMPTY;
          end else begin
            state_n = ST_ONE;
          end
        end
        ST_FULL:  state_n = take_s ? ST_ONE : ST_FULL;
        default:  state_n = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs decoded straight from the state register bits.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    case (state_r)
      ST_EMPTY: begin out_valid = 1'b0; in_ready = 1'b1; end
      ST_ONE:   begin out_valid = 1'b1; in_ready = 1'b1; end
      ST_FULL:  begin out_valid = 1'b1; in_ready = 1'b0; end
      default:  begin out_valid = 1'b0; in_ready = 1'b1; end
    endcase
  end

  // Output and skid entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r  <= {$bits(dec_t){1'b0}};
      skid_r <= {$bits(dec_t){1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: if (accept_s) out_r <= dec_s;
        ST_ONE: begin
          if (accept_s && take_s) begin
            out_r <= dec_s;
          end else if (accept_s) begin
            skid_r <= dec_s;
          end
        end
        ST_FULL:  if (take_s) out_r <= skid_r;
        default:  out_r <= out_r;
      endcase
    end
  end

  // Saturating count of illegal entries handed to the consumer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ill_cnt_r <= {ILL_CNT_W{1'b0}};
    end else if (take_s && out_r.illegal && (ill_cnt_r != {ILL_CNT_W{1'b1}})) begin
      ill_cnt_r <= ill_cnt_r + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_pc      = out_r.pc;
  assign out_opcode  = out_r.opcode;
  assign out_funct   = out_r.funct;
  assign out_rd      = out_r.rd;
  assign out_rs1     = out_r.rs1;
  assign out_rs2     = out_r.rs2;
  assign out_imm     = out_r.imm;
  assign out_fmt     = out_r.fmt;
  assign out_is_word = out_r.is_word;
  assign out_illegal = out_r.illegal;
  assign ill_count   = ill_cnt_r;

endmodule

// File: tb/tb_rvi_decode_stage.sv
// Bench for rvi_decode_stage: XLEN=32 and XLEN=64 instances share stimulus and are
// checked against a queue-based reference built from the RISC-V decode rules.
module tb_rvi_decode_stage;

  localparam logic [6:0] L_LOAD = 7'b0000011, L_MISC = 7'b0001111, L_OPIMM = 7'b0010011,
                         L_AUIPC = 7'b0010111, L_OPIMM32 = 7'b0011011, L_STORE = 7'b0100011,
                         L_OP = 7'b0110011, L_LUI = 7'b0110111, L_OP32 = 7'b0111011,
                         L_BRANCH = 7'b1100011, L_JALR = 7'b1100111, L_JAL = 7'b1101111,
                         L_SYSTEM = 7'b1110011;
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;
  localparam int CNT_A_MAX = 65535;
  localparam int CNT_B_MAX = 7;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [9:0]  funct;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        is_word;
    logic        illegal;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, a_out_is_word, a_out_illegal;
  logic [31:0] a_out_pc, a_out_imm;
  logic [6:0]  a_out_opcode;
  logic [9:0]  a_out_funct;
  logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
  logic [2:0]  a_out_fmt;
  logic [15:0] a_ill_count;

  logic        b_in_ready, b_out_valid, b_out_is_word, b_out_illegal;
  logic [63:0] b_out_pc, b_out_imm;
  logic [6:0]  b_out_opcode;
  logic [9:0]  b_out_funct;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
  logic [2:0]  b_out_fmt;
  logic [2:0]  b_ill_count;

  int   nvec = 0;
  int   nerr = 0;
  int   cnt_a = 0;
  int   cnt_b = 0;
  bit   last_acc;
  ent_t q[$];

  rvi_decode_stage #(.XLEN(32), .ILL_CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_opcode(a_out_opcode), .out_funct(a_out_funct), .out_rd(a_out_rd),
    .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_is_word(a_out_is_word), .out_illegal(a_out_illegal), .ill_count(a_ill_count));

  rvi_decode_stage #(.XLEN(64), .ILL_CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_opcode(b_out_opcode), .out_funct(b_out_funct), .out_rd(b_out_rd),
    .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .out_is_word(b_out_is_word), .out_illegal(b_out_illegal), .ill_count(b_ill_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w, input bit rv64);
    exp_t e;
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    bit sh = (f3 == 3'd1) || (f3 == 3'd5);
    e = '0;
    e.opcode = w[6:0];
    e.funct  = {7'd0, f3};
    e.fmt    = F_I;
    case (w[6:0])
      L_LOAD:   e.illegal = (f3 == 3'd7) || (!rv64 && (f3 == 3'd3 || f3 == 3'd6));
      L_MISC, L_SYSTEM: e.fmt = F_I;
      L_OPIMM, L_OPIMM32: begin
        if (sh) e.funct = rv64 ? {w[31:26], 1'b0, f3} : {f7, f3};
        if (w[6:0] == L_OPIMM32) begin
          e.illegal = !rv64;
          e.is_word = rv64;
        end else begin
          e.illegal = !rv64 && sh && w[25];
        end
      end
      L_JALR:   e.illegal = (f3 != 3'd0);
      L_STORE:  begin e.fmt = F_S; e.illegal = rv64 ? (f3 > 3'd3) : (f3 > 3'd2); end
      L_BRANCH: begin e.fmt = F_B; e.illegal = (f3 == 3'd2) || (f3 == 3'd3); end
      L_LUI, L_AUIPC: e.fmt = F_U;
      L_JAL:    e.fmt = F_J;
      L_OP: begin
        e.fmt = F_R;
        e.funct = {f7, f3};
        e.illegal = !(f7 == 7'h00 || f7 == 7'h20) || (f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5));
      end
      L_OP32:   begin e.fmt = F_R; e.funct = {f7, f3}; e.illegal = !rv64; e.is_word = rv64; end
      default:  begin e.fmt = F_R; e.illegal = 1'b1; end
    endcase
    if (w[1:0] != 2'b11) e.illegal = 1'b1;
    if (e.fmt inside {F_R, F_I, F_U, F_J}) e.rd  = w[11:7];
    if (e.fmt inside {F_R, F_I, F_S, F_B}) e.rs1 = w[19:15];
    if (e.fmt inside {F_R, F_S, F_B})      e.rs2 = w[24:20];
    case (e.fmt)
      F_I: e.imm = longint'($signed(w[31:20]));
      F_S: e.imm = longint'($signed({w[31:25], w[11:7]}));
      F_B: e.imm = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      F_U: e.imm = longint'($signed({w[31:12], 12'h000}));
      F_J: e.imm = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: e.imm = 64'd0;
    endcase
    return e;
  endfunction

  task automatic check_outputs();
    exp_t ea, eb;
    ent_t f;
    bit   v = (q.size() > 0);
    chk("a_out_valid", a_out_valid, v);
    chk("b_out_valid", b_out_valid, v);
    chk("a_in_ready", a_in_ready, q.size() < 2);
    chk("b_in_ready", b_in_ready, q.size() < 2);
    chk("a_ill_count", a_ill_count, cnt_a);
    chk("b_ill_count", b_ill_count, cnt_b);
    if (v) begin
      f  = q[0];
      ea = ref_decode(f.inst, 1'b0);
      eb = ref_decode(f.inst, 1'b1);
      chk("a_pc", a_out_pc, f.pc[31:0]);         chk("b_pc", b_out_pc, f.pc);
      chk("a_opcode", a_out_opcode, ea.opcode);  chk("b_opcode", b_out_opcode, eb.opcode);
      chk("a_funct", a_out_funct, ea.funct);     chk("b_funct", b_out_funct, eb.funct);
      chk("a_rd", a_out_rd, ea.rd);              chk("b_rd", b_out_rd, eb.rd);
      chk("a_rs1", a_out_rs1, ea.rs1);           chk("b_rs1", b_out_rs1, eb.rs1);
      chk("a_rs2", a_out_rs2, ea.rs2);           chk("b_rs2", b_out_rs2, eb.rs2);
      chk("a_imm", a_out_imm, ea.imm[31:0]);     chk("b_imm", b_out_imm, eb.imm);
      chk("a_fmt", a_out_fmt, ea.fmt);           chk("b_fmt", b_out_fmt, eb.fmt);
      chk("a_is_word", a_out_is_word, ea.is_word); chk("b_is_word", b_out_is_word, eb.is_word);
      chk("a_illegal", a_out_illegal, ea.illegal); chk("b_illegal", b_out_illegal, eb.illegal);
    end
  endtask

  // One clock: check at the negedge, advance the queue model across the posedge.
  task automatic cycle();
    bit   take, acc;
    ent_t e;
    check_outputs();
    take = (q.size() > 0) && out_ready;
    acc  = in_valid && (q.size() < 2);
    @(posedge clk);
    if (take) begin
      e = q.pop_front();
      if (ref_decode(e.inst, 1'b0).illegal && cnt_a < CNT_A_MAX) cnt_a++;
      if (ref_decode(e.inst, 1'b1).illegal && cnt_b < CNT_B_MAX) cnt_b++;
    end
    if (flush) q.delete();
    else if (acc) q.push_back({in_inst, in_pc});
    last_acc = acc && !flush;
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w, input logic [63:0] pc);
    int n = 0;
    in_valid = 1'b1;
    in_inst  = w;
    in_pc    = pc;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 20);
    in_valid = 1'b0;
    if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  // Entered at a negedge; pulses rst between clock edges and checks the async clear.
  task automatic async_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_a_valid", a_out_valid, 0); chk("rst_b_valid", b_out_valid, 0);
    chk("rst_a_ready", a_in_ready, 1);  chk("rst_b_ready", b_in_ready, 1);
    chk("rst_a_cnt", a_ill_count, 0);   chk("rst_b_cnt", b_ill_count, 0);
    chk("rst_a_pc", a_out_pc, 0);       chk("rst_b_imm", b_out_imm, 0);
    q.delete();
    cnt_a = 0;
    cnt_b = 0;
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [0:12] = '{L_LOAD, L_MISC, L_OPIMM, L_AUIPC, L_OPIMM32, L_STORE, L_OP,
                               L_LUI, L_OP32, L_BRANCH, L_JALR, L_JAL, L_SYSTEM};
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 4) != 0) begin
      r[6:0] = ops[$urandom_range(0, 12)];
      if (r[6:0] == L_OP && $urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end
    return r;
  endfunction

  logic [31:0] stall_list [0:4] = '{32'h00100093, 32'h00200113, 32'h003081B3, 32'h00412023, 32'h0000006F};

  initial begin
    int idx, guard;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'd0; in_pc = 64'd0;
    @(negedge clk);
    async_reset();

    // ADDI / SUB / BEQ back to back
    send(32'h00500093, 64'h100);
    chk("addi_valid", a_out_valid, 1);  chk("addi_opcode", a_out_opcode, 7'b0010011);
    chk("addi_rd", a_out_rd, 1);        chk("addi_rs1", a_out_rs1, 0);
    chk("addi_imm", a_out_imm, 5);      chk("addi_fmt", a_out_fmt, 1);
    chk("addi_funct", a_out_funct, 0);  chk("addi_illegal", a_out_illegal, 0);
    chk("addi_pc", a_out_pc, 32'h100);
    send(32'h402081B3, 64'h104);
    chk("sub_funct", a_out_funct, 10'b0100000000); chk("sub_fmt", a_out_fmt, 0);
    chk("sub_rd", a_out_rd, 3); chk("sub_rs1", a_out_rs1, 1); chk("sub_rs2", a_out_rs2, 2);
    chk("sub_imm", a_out_imm, 0);
    send(32'hFE000EE3, 64'h108);
    chk("beq_fmt", a_out_fmt, 3);  chk("beq_imm32", a_out_imm, 32'hFFFFFFFC);
    chk("beq_rd", a_out_rd, 0);    chk("beq_funct", a_out_funct, 0);
    chk("beq_imm64", b_out_imm, 64'hFFFFFFFFFFFFFFFC);
    cycle();

    // five-instruction stream with a three-cycle consumer stall
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_inst = stall_list[idx]; in_pc = 64'h200 + 64'(4 * idx);
      cycle();
      if (last_acc) idx++;
    end
    chk("stall_accepts", idx, 2);
    chk("stall_in_ready", a_in_ready, 0);
    out_ready = 1'b1;
    guard = 0;
    while (idx < 5 && guard < 30) begin
      in_valid = 1'b1; in_inst = stall_list[idx]; in_pc = 64'h200 + 64'(4 * idx);
      cycle();
      if (last_acc) idx++;
      guard++;
    end
    chk("stall_all_sent", idx, 5);
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("stall_drained", a_out_valid, 0);

    // illegal counting at both XLENs
    async_reset();
    send(32'h00000000, 64'h300);
    send(32'h0010009B, 64'h304);
    chk("addiw_a_illegal", a_out_illegal, 1); chk("addiw_b_illegal", b_out_illegal, 0);
    chk("addiw_b_is_word", b_out_is_word, 1); chk("addiw_b_imm", b_out_imm, 1);
    cycle();
    chk("ill_a_count", a_ill_count, 2);
    chk("ill_b_count", b_ill_count, 1);

    // flush while FULL with a simultaneous input
    out_ready = 1'b0;
    send(32'h00100093, 64'h400);
    send(32'h00200113, 64'h404);
    chk("full_in_ready", a_in_ready, 0);
    in_valid = 1'b1; in_inst = 32'h00300193; in_pc = 64'h408; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", a_out_valid, 0);
    chk("flush_ready", a_in_ready, 1);
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("flush_no_ghost", b_out_valid, 0);

    // randomized traffic with one mid-stream reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) async_reset();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = rand_inst();
      in_pc     = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
